// File: rtl/calc1_arbiter_if.sv
`default_nettype none
// calc1_arbiter_if -- requester, ALU and response bundle; per-port fields packed port 1 first. rev 1.0
interface calc1_arbiter_if;
  logic [1:4]   req_valid;
  logic [0:15]  req_cmd;
  logic [0:127] req_op1;
  logic [0:127] req_op2;
  logic [1:4]   req_ready;
  logic         alu_valid;
  logic [3:0]   alu_cmd;
  logic [31:0]  alu_op1;
  logic [31:0]  alu_op2;
  logic         alu_ready;
  logic         alu_resp_valid;
  logic [1:0]   alu_resp;
  logic [31:0]  alu_data;
  logic [0:7]   out_resp;
  logic [0:127] out_data;

  modport master (
    input  req_valid, req_cmd, req_op1, req_op2,
    input  alu_ready, alu_resp_valid, alu_resp, alu_data,
    output req_ready, alu_valid, alu_cmd, alu_op1, alu_op2,
    output out_resp, out_data
  );

  modport slave (
    output req_valid, req_cmd, req_op1, req_op2,
    output alu_ready, alu_resp_valid, alu_resp, alu_data,
    input  req_ready, alu_valid, alu_cmd, alu_op1, alu_op2,
    input  out_resp, out_data
  );
endinterface
`default_nettype wire

// File: rtl/calc1_arbiter.sv
`default_nettype none
// calc1_arbiter -- round-robin front end sharing one ALU among four requesters,
// one command in flight, with response timeout. rev 1.0
module calc1_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  wire logic       c_clk,
  input  wire logic       reset,
  calc1_arbiter_if.master bus
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t        r_state, w_next;
  logic [1:0]    r_ptr, r_grant;
  logic [3:0]    r_cmd;
  logic [31:0]   r_op1, r_op2, r_data;
  logic [1:0]    r_resp;
  logic [CW-1:0] r_cnt;

  logic [3:0]    w_vld, w_ready;
  logic [1:0]    w_idx, w_gnt;
  logic          w_any, w_legal, w_expired, w_got;
  logic [3:0]    w_cmd;
  logic [31:0]   w_op1, w_op2;

  always_comb begin
    w_any = 1'b0;
    w_gnt = r_ptr;
    w_idx = r_ptr;
    for (int p = 0; p < 4; p++) w_vld[p] = bus.req_valid[p+1];
    // Scan from r_ptr itself (lowest priority) downwards in priority order so the last hit is the first port after r_ptr.
    for (int k = 4; k >= 1; k--) begin
      w_idx = r_ptr + 2'(k);
      if (w_vld[w_idx]) begin
        w_any = 1'b1;
        w_gnt = w_idx;
      end
    end
  end

  assign w_cmd     = bus.req_cmd[{w_gnt, 2'b00} +: 4];
  assign w_op1     = bus.req_op1[{w_gnt, 5'b00000} +: 32];
  assign w_op2     = bus.req_op2[{w_gnt, 5'b00000} +: 32];
  assign w_legal   = (w_cmd == 4'd1) || (w_cmd == 4'd2) || (w_cmd == 4'd5) || (w_cmd == 4'd6);
  assign w_expired = (r_cnt == C_LAST);
  assign w_got     = (r_state == S_WAIT) && bus.alu_resp_valid;

  always_ff @(posedge c_clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_ready       = 4'b0000;
    bus.alu_valid = 1'b0;
    bus.alu_cmd   = '0;
    bus.alu_op1   = '0;
    bus.alu_op2   = '0;
    bus.out_resp  = '0;
    bus.out_data  = '0;
    if (reset) begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            w_ready[w_gnt] = 1'b1;
            if (w_legal)              w_next = S_ISSUE;
            else if (w_cmd != 4'd0)   w_next = S_RESP;
          end
        end
        S_ISSUE: begin
          bus.alu_valid = 1'b1;
          bus.alu_cmd   = r_cmd;
          bus.alu_op1   = r_op1;
          bus.alu_op2   = r_op2;
          if (w_expired)          w_next = S_RESP;
          else if (bus.alu_ready) w_next = S_WAIT;
        end
        S_WAIT: begin
          if (w_got || w_expired) w_next = S_RESP;
        end
        S_RESP: begin
          bus.out_resp[{r_grant, 1'b0} +: 2]      = r_resp;
          bus.out_data[{r_grant, 5'b00000} +: 32] = r_data;
          w_next = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
    for (int p = 0; p < 4; p++) bus.req_ready[p+1] = w_ready[p];
  end

  always_ff @(posedge c_clk) begin
    if (!reset) begin
      r_ptr   <= 2'd3;
      r_grant <= 2'd0;
      r_cmd   <= 4'd0;
      r_op1   <= 32'd0;
      r_op2   <= 32'd0;
      r_cnt   <= '0;
      r_resp  <= 2'd0;
      r_data  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_gnt;
            r_cmd   <= w_cmd;
            r_op1   <= w_op1;
            r_op2   <= w_op2;
            r_cnt   <= '0;
            // Pre-load the invalid-command reply; ALU paths always overwrite it before RESP.
            r_resp  <= 2'd2;
            r_data  <= 32'd0;
            if (w_cmd == 4'd0) r_ptr <= w_gnt;
          end
        end
        S_ISSUE, S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_got) begin
            r_resp <= bus.alu_resp;
            r_data <= bus.alu_data;
          end else if (w_expired) begin
            r_resp <= 2'd3;
            r_data <= 32'd0;
          end
        end
        S_RESP: r_ptr <= r_grant;
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_calc1_arbiter.sv
`default_nettype none
// tb_calc1_arbiter -- directed vectors against a grant/ALU/response scoreboard, TIMEOUT = 8.
module tb_calc1_arbiter;
  localparam int TMO = 8;

  logic c_clk = 1'b0;
  logic reset = 1'b0;

  calc1_arbiter_if bus();

  calc1_arbiter #(.TIMEOUT(TMO)) dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 c_clk = ~c_clk;

  typedef struct {
    int          port;
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat;
  } rsp_t;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    int          vcyc;
  } alu_t;

  rsp_t rsp_q[$];
  alu_t alu_q[$];
  int   gnt_q[$];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int n_tmo   = 0;
  int zreq    = 0;
  bit done    = 1'b0;

  int rdy_delay = 0;
  int rsp_delay = 0;
  bit silent    = 1'b0;
  int inj_req   = 0;

  always @(posedge c_clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: every comparison happens here, on the falling edge.
  initial begin : mon
    alu_t        cur;
    rsp_t        e;
    bit          act;
    bit          stable;
    int          vc, last_acc, stray, zseen, g;
    logic [1:4]  eg;
    logic [0:7]  er;
    logic [0:127] ed;
    act = 1'b0; stable = 1'b1; vc = 0; last_acc = 0; stray = 0; zseen = 0;
    forever begin
      @(negedge c_clk);
      if (zreq != zseen) begin
        zseen = zreq;
        check({bus.req_ready, bus.alu_valid, bus.alu_cmd, bus.alu_op1, bus.alu_op2, bus.out_resp, bus.out_data} == '0,
              "outputs_zero",
              256'({bus.req_ready, bus.alu_valid, bus.alu_cmd, bus.alu_op1, bus.alu_op2, bus.out_resp, bus.out_data}), 256'(0));
      end
      if (bus.req_ready != 4'b0000) begin
        last_acc = cyc;
        if (gnt_q.size() == 0) check(1'b0, "grant_unexpected", 256'(bus.req_ready), 256'(0));
        else begin
          g = gnt_q.pop_front();
          eg = '0;
          eg[g] = 1'b1;
          check(bus.req_ready == eg, "grant", 256'(bus.req_ready), 256'(eg));
        end
      end
      if (bus.alu_valid) begin
        if (!act) begin
          if (alu_q.size() == 0) check(1'b0, "alu_unexpected", 256'({bus.alu_cmd, bus.alu_op1, bus.alu_op2}), 256'(0));
          else begin
            cur = alu_q.pop_front();
            act = 1'b1; vc = 0; stable = 1'b1;
          end
        end
        if (act) begin
          vc++;
          if (bus.alu_cmd !== cur.cmd || bus.alu_op1 !== cur.op1 || bus.alu_op2 !== cur.op2) stable = 1'b0;
          if (bus.alu_ready) begin
            check(stable && vc == cur.vcyc, "alu_issue",
                  256'({bus.alu_cmd, bus.alu_op1, bus.alu_op2, 32'(vc)}),
                  256'({cur.cmd, cur.op1, cur.op2, 32'(cur.vcyc)}));
            act = 1'b0;
          end
        end
      end else if (act) begin
        check(1'b0, "alu_dropped", 256'(vc), 256'(cur.vcyc));
        act = 1'b0;
      end
      if (bus.out_resp != '0) begin
        if (rsp_q.size() == 0) check(1'b0, "resp_unexpected", 256'({bus.out_resp, bus.out_data}), 256'(0));
        else begin
          e = rsp_q.pop_front();
          er = '0; ed = '0;
          er[2*(e.port-1) +: 2]  = e.resp;
          ed[32*(e.port-1) +: 32] = e.data;
          check(bus.out_resp == er && bus.out_data == ed, "resp",
                256'({bus.out_resp, bus.out_data}), 256'({er, ed}));
          if (e.lat >= 0) check(cyc - last_acc == e.lat, "latency", 256'(cyc - last_acc), 256'(e.lat));
        end
      end else if (bus.out_data != '0) stray++;
      if ($countones(bus.req_ready) > 1) stray++;
      if (done) begin
        check(rsp_q.size() == 0 && gnt_q.size() == 0 && alu_q.size() == 0, "drained",
              256'({32'(rsp_q.size()), 32'(gnt_q.size()), 32'(alu_q.size())}), 256'(0));
        check(stray == 0, "stray_outputs", 256'(stray), 256'(0));
        check(n_tmo == 0, "wait_budget", 256'(n_tmo), 256'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
      end
    end
  end

  // ALU model: accepts after rdy_delay cycles, answers rsp_delay cycles after acceptance.
  initial begin : alu
    bit          pend;
    int          wcnt, rc, inj_done;
    logic [31:0] rd;
    pend = 1'b0; wcnt = 0; rc = 0; inj_done = 0; rd = 32'd0;
    bus.alu_ready = 1'b0; bus.alu_resp_valid = 1'b0; bus.alu_resp = 2'd0; bus.alu_data = 32'd0;
    forever begin
      @(posedge c_clk); #1;
      bus.alu_ready = 1'b0; bus.alu_resp_valid = 1'b0; bus.alu_resp = 2'd0; bus.alu_data = 32'd0;
      if (pend) begin
        if (wcnt == 0) begin
          bus.alu_resp_valid = 1'b1; bus.alu_resp = 2'd1; bus.alu_data = rd; pend = 1'b0;
        end else wcnt--;
      end else if (inj_req != inj_done) begin
        inj_done = inj_req;
        bus.alu_resp_valid = 1'b1; bus.alu_resp = 2'd1; bus.alu_data = 32'h0000BEEF;
      end
      if (bus.alu_valid) begin
        if (rc >= rdy_delay) begin
          bus.alu_ready = 1'b1;
          rc = 0;
          if (!silent) begin
            pend = 1'b1;
            wcnt = rsp_delay;
            case (bus.alu_cmd)
              4'd1:    rd = bus.alu_op1 + bus.alu_op2;
              4'd2:    rd = bus.alu_op1 - bus.alu_op2;
              4'd5:    rd = bus.alu_op1 << bus.alu_op2[4:0];
              4'd6:    rd = bus.alu_op1 >> bus.alu_op2[4:0];
              default: rd = 32'd0;
            endcase
          end
        end else rc++;
      end else rc = 0;
    end
  end

  task automatic tick();
    logic [1:4] rdy;
    @(negedge c_clk);
    rdy = bus.req_ready;
    @(posedge c_clk); #1;
    bus.req_valid = bus.req_valid & ~rdy;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic req(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid[p]            = 1'b1;
    bus.req_cmd[4*(p-1) +: 4]   = c;
    bus.req_op1[32*(p-1) +: 32] = a;
    bus.req_op2[32*(p-1) +: 32] = b;
  endtask

  task automatic exp_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input int v);
    alu_t t;
    t.cmd = c; t.op1 = a; t.op2 = b; t.vcyc = v;
    alu_q.push_back(t);
  endtask

  task automatic exp_rsp(input int p, input logic [1:0] r, input logic [31:0] d, input int l);
    rsp_t t;
    t.port = p; t.resp = r; t.data = d; t.lat = l;
    rsp_q.push_back(t);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || gnt_q.size() != 0 || alu_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (rsp_q.size() != 0 || gnt_q.size() != 0 || alu_q.size() != 0) begin
      n_tmo++;
      $display("FAIL wait_budget: %0d resp, %0d grant, %0d alu entries pending after %0d cycles",
               rsp_q.size(), gnt_q.size(), alu_q.size(), n);
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    zreq++;
    ticks(2);
    reset = 1'b1;
    tick();
  endtask

  initial begin : stim
    bus.req_valid = '0; bus.req_cmd = '0; bus.req_op1 = '0; bus.req_op2 = '0;
    @(posedge c_clk); #1;
    zreq++;
    ticks(3);
    reset = 1'b1;
    tick();
    zreq++;
    tick();

    // Port 2 add 5+7, best-case latency
    gnt_q.push_back(2); exp_alu(4'd1, 32'd5, 32'd7, 1); exp_rsp(2, 2'd1, 32'd12, 3);
    req(2, 4'd1, 32'd5, 32'd7);
    drain(40); ticks(2);

    // All four ports at once after reset: grants 1,2,3,4
    reset_pulse();
    for (int p = 1; p <= 4; p++) begin
      gnt_q.push_back(p);
      exp_alu(4'd1, 32'(10 * p), 32'(p), 1);
    end
    exp_rsp(1, 2'd1, 32'd11, 3); exp_rsp(2, 2'd1, 32'd22, 3);
    exp_rsp(3, 2'd1, 32'd33, 3); exp_rsp(4, 2'd1, 32'd44, 3);
    for (int p = 1; p <= 4; p++) req(p, 4'd1, 32'(10 * p), 32'(p));
    drain(80); ticks(2);

    // Port 3 illegal command 9
    gnt_q.push_back(3); exp_rsp(3, 2'd2, 32'd0, 1);
    req(3, 4'd9, 32'h1234, 32'h5678);
    drain(20); ticks(2);

    // Port 1 command 0 discarded; pointer moves to port 1, so port 2 wins next
    gnt_q.push_back(1);
    req(1, 4'd0, 32'd77, 32'd77);
    drain(20); ticks(2);
    gnt_q.push_back(2); gnt_q.push_back(1);
    exp_alu(4'd1, 32'd3, 32'd4, 1); exp_alu(4'd2, 32'd9, 32'd1, 1);
    exp_rsp(2, 2'd1, 32'd7, 3); exp_rsp(1, 2'd1, 32'd8, 3);
    req(2, 4'd1, 32'd3, 32'd4); req(1, 4'd2, 32'd9, 32'd1);
    drain(40); ticks(2);

    // Port 1 sub, ALU silent: internal error after TIMEOUT cycles, late response ignored
    silent = 1'b1;
    gnt_q.push_back(1); exp_alu(4'd2, 32'd50, 32'd8, 1); exp_rsp(1, 2'd3, 32'd0, 9);
    req(1, 4'd2, 32'd50, 32'd8);
    drain(40); tick();
    inj_req++;
    ticks(6);
    silent = 1'b0;

    // Response arriving on the last counter value beats the timeout
    rsp_delay = 6;
    gnt_q.push_back(2); exp_alu(4'd1, 32'd100, 32'd23, 1); exp_rsp(2, 2'd1, 32'd123, 9);
    req(2, 4'd1, 32'd100, 32'd23);
    drain(40); ticks(2);
    rsp_delay = 0;

    // Port 4 shift left with alu_ready low for 3 cycles
    rdy_delay = 3;
    gnt_q.push_back(4); exp_alu(4'd5, 32'd3, 32'd4, 4); exp_rsp(4, 2'd1, 32'd48, 6);
    req(4, 4'd5, 32'd3, 32'd4);
    drain(40); ticks(2);
    rdy_delay = 0;

    // Reset while waiting on the ALU: no response, then port 1 wins
    rsp_delay = 4;
    gnt_q.push_back(3); exp_alu(4'd6, 32'd64, 32'd2, 1);
    req(3, 4'd6, 32'd64, 32'd2);
    ticks(3);
    reset = 1'b0;
    zreq++;
    ticks(2);
    reset = 1'b1;
    ticks(8);
    rsp_delay = 0;
    gnt_q.push_back(1); gnt_q.push_back(2); gnt_q.push_back(4);
    exp_alu(4'd1, 32'd1, 32'd1, 1); exp_alu(4'd1, 32'd2, 32'd2, 1); exp_alu(4'd1, 32'd7, 32'd8, 1);
    exp_rsp(1, 2'd1, 32'd2, 3); exp_rsp(2, 2'd1, 32'd4, 3); exp_rsp(4, 2'd1, 32'd15, 3);
    req(1, 4'd1, 32'd1, 32'd1); req(2, 4'd1, 32'd2, 32'd2); req(4, 4'd1, 32'd7, 32'd8);
    drain(60); ticks(3);

    done = 1'b1;
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
`default_nettype wire
